// File: rtl/clock_pkg.sv
// Shared constants and helpers for the clock time-setting controller.
// State encodings, field limits, per-field blank masks and wrap arithmetic.
package clock_pkg;

    localparam int FIELD_W = 6;
    typedef logic [FIELD_W-1:0] field_t;

    localparam field_t HR_MAX  = 6'd23;
    localparam field_t MIN_MAX = 6'd59;
    localparam field_t SEC_MAX = 6'd59;

    // FSM states, kept as plain constants for compatibility with older code.
    typedef logic [2:0] state_t;
    localparam state_t ST_RUN     = 3'd0;
    localparam state_t ST_SET_HR  = 3'd1;
    localparam state_t ST_SET_MIN = 3'd2;
    localparam state_t ST_SET_SEC = 3'd3;
    localparam state_t ST_COMMIT  = 3'd4;

    // Digit blank masks: bit0 = sec units ... bit5 = hr tens.
    localparam logic [5:0] BLANK_NONE = 6'b000000;
    localparam logic [5:0] BLANK_SEC  = 6'b000011;
    localparam logic [5:0] BLANK_MIN  = 6'b001100;
    localparam logic [5:0] BLANK_HR   = 6'b110000;

    // Increment with wrap to zero past max_v (out-of-range values also wrap).
    function automatic field_t wrap_inc(input field_t v, input field_t max_v);
        if (v >= max_v) begin
            return 6'd0;
        end else begin
            return v + 6'd1;
        end
    endfunction

    // Decrement with wrap from zero to max_v (out-of-range values land on max_v).
    function automatic field_t wrap_dec(input field_t v, input field_t max_v);
        if ((v == 6'd0) || (v > max_v)) begin
            return max_v;
        end else begin
            return v - 6'd1;
        end
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Divide counter: phase toggles every PERIOD cycles; clr restarts at phase 0.
// Used for the field blink and for the idle timeout in set mode.
module blink_timer #(
    parameter longint unsigned PERIOD = 64'd4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic phase
);

    localparam int CW = (PERIOD > 64'd1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 64'd1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_r;
    logic          phase_r;

    // Count up to LAST, then wrap and flip the phase; clear wins over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (clr) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r   <= '0;
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + ONE;
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the 7-segment clock: freezes the counters,
// edits hours -> minutes -> seconds with blinking, then issues a one-cycle load.
// Optional build macro SET_TIMEOUT_EN: abort set mode after TIMEOUT_S idle seconds.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned BLINK_HZ  = 2,
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_hr,
    output logic       run_en,
    output logic       load,
    output logic [5:0] load_sec,
    output logic [5:0] load_min,
    output logic [5:0] load_hr,
    output logic [5:0] disp_sec,
    output logic [5:0] disp_min,
    output logic [5:0] disp_hr,
    output logic [5:0] blank
);

    localparam longint unsigned BLINK_RAW    = 64'(CLK_HZ) / (64'd2 * 64'(BLINK_HZ));
    localparam longint unsigned BLINK_PERIOD = (BLINK_RAW > 64'd0) ? BLINK_RAW : 64'd1;

    // Buttons packed as {dec, inc, mode}.
    logic [2:0] btn_q_r;
    logic [2:0] btn_prev_r;
    logic [2:0] btn_arm_r;
    logic [2:0] press_s;

    state_t state_r;
    state_t state_nxt_s;
    logic   run_en_r;
    logic   load_r;
    field_t load_hr_r, load_min_r, load_sec_r;
    field_t edit_hr_r, edit_min_r, edit_sec_r;

    logic       in_set_s;
    logic       capture_s;
    logic       edit_s;
    logic       edit_up_s;
    logic       timeout_s;
    logic       blink_clr_s;
    logic       blink_phase_s;
    logic [5:0] blank_mask_s;

    // A button only arms once it has been seen low, so a level held through
    // reset never looks like a press.
    assign press_s = btn_q_r & ~btn_prev_r & btn_arm_r;

    // Register button levels and keep the edge-detect history.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q_r    <= 3'b000;
            btn_prev_r <= 3'b000;
            btn_arm_r  <= 3'b000;
        end else begin
            btn_q_r    <= {btn_dec, btn_inc, btn_mode};
            btn_prev_r <= btn_q_r;
            btn_arm_r  <= btn_arm_r | ~{btn_dec, btn_inc, btn_mode};
        end
    end

    assign in_set_s  = (state_r == ST_SET_HR) || (state_r == ST_SET_MIN) ||
                       (state_r == ST_SET_SEC);
    assign capture_s = (state_r == ST_RUN) && press_s[0];
    // Mode has priority; inc together with dec cancels out.
    assign edit_s    = in_set_s && !press_s[0] && (press_s[1] ^ press_s[2]);
    assign edit_up_s = press_s[1];

`ifdef SET_TIMEOUT_EN
    localparam longint unsigned IDLE_CYCLES = 64'(TIMEOUT_S) * 64'(CLK_HZ);
    // The phase rises one cycle after the terminal count, so count one fewer.
    localparam longint unsigned IDLE_PERIOD = (IDLE_CYCLES > 64'd2) ? (IDLE_CYCLES - 64'd1) : 64'd1;

    logic idle_clr_s;
    logic idle_phase_s;

    assign idle_clr_s = !in_set_s || (|press_s);
    assign timeout_s  = idle_phase_s && !(|press_s);

    blink_timer #(
        .PERIOD (IDLE_PERIOD)
    ) u_idle_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (idle_clr_s),
        .phase (idle_phase_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state selection for the set sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (press_s[0]) state_nxt_s = ST_SET_HR;
                else            state_nxt_s = ST_RUN;
            end
            ST_SET_HR: begin
                if (press_s[0])     state_nxt_s = ST_SET_MIN;
                else if (timeout_s) state_nxt_s = ST_RUN;
                else                state_nxt_s = ST_SET_HR;
            end
            ST_SET_MIN: begin
                if (press_s[0])     state_nxt_s = ST_SET_SEC;
                else if (timeout_s) state_nxt_s = ST_RUN;
                else                state_nxt_s = ST_SET_MIN;
            end
            ST_SET_SEC: begin
                if (press_s[0])     state_nxt_s = ST_COMMIT;
                else if (timeout_s) state_nxt_s = ST_RUN;
                else                state_nxt_s = ST_SET_SEC;
            end
            ST_COMMIT: state_nxt_s = ST_RUN;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // State register plus registered run/load controls and load values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            run_en_r   <= 1'b1;
            load_r     <= 1'b0;
            load_hr_r  <= 6'd0;
            load_min_r <= 6'd0;
            load_sec_r <= 6'd0;
        end else begin
            state_r  <= state_nxt_s;
            run_en_r <= (state_nxt_s == ST_RUN);
            load_r   <= (state_nxt_s == ST_COMMIT);
            if (state_nxt_s == ST_COMMIT) begin
                load_hr_r  <= edit_hr_r;
                load_min_r <= edit_min_r;
                load_sec_r <= edit_sec_r;
            end
        end
    end

    // Edit registers: snapshot the live time on entry, then step the selected field.
    always_ff @(posedge clk) begin
        if (rst) begin
            edit_hr_r  <= 6'd0;
            edit_min_r <= 6'd0;
            edit_sec_r <= 6'd0;
        end else if (capture_s) begin
            edit_hr_r  <= cur_hr;
            edit_min_r <= cur_min;
            edit_sec_r <= cur_sec;
        end else if (edit_s) begin
            case (state_r)
                ST_SET_HR:  edit_hr_r  <= edit_up_s ? wrap_inc(edit_hr_r, HR_MAX)
                                                    : wrap_dec(edit_hr_r, HR_MAX);
                ST_SET_MIN: edit_min_r <= edit_up_s ? wrap_inc(edit_min_r, MIN_MAX)
                                                    : wrap_dec(edit_min_r, MIN_MAX);
                ST_SET_SEC: edit_sec_r <= edit_up_s ? wrap_inc(edit_sec_r, SEC_MAX)
                                                    : wrap_dec(edit_sec_r, SEC_MAX);
                default: begin
                end
            endcase
        end
    end

    // Restart the blink on every state change and every edit so the new value shows at once.
    assign blink_clr_s = (state_nxt_s != state_r) || edit_s;

    blink_timer #(
        .PERIOD (BLINK_PERIOD)
    ) u_blink_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (blink_clr_s),
        .phase (blink_phase_s)
    );

    // Pick the blank mask of the field being edited.
    always_comb begin
        blank_mask_s = BLANK_NONE;
        case (state_r)
            ST_SET_HR:  blank_mask_s = BLANK_HR;
            ST_SET_MIN: blank_mask_s = BLANK_MIN;
            ST_SET_SEC: blank_mask_s = BLANK_SEC;
            default:    blank_mask_s = BLANK_NONE;
        endcase
    end

    // Display mux: live time while running, edit values otherwise.
    always_comb begin
        if (state_r == ST_RUN) begin
            disp_hr  = cur_hr;
            disp_min = cur_min;
            disp_sec = cur_sec;
        end else begin
            disp_hr  = edit_hr_r;
            disp_min = edit_min_r;
            disp_sec = edit_sec_r;
        end
    end

    assign blank    = blink_phase_s ? blank_mask_s : BLANK_NONE;
    assign run_en   = run_en_r;
    assign load     = load_r;
    assign load_hr  = load_hr_r;
    assign load_min = load_min_r;
    assign load_sec = load_sec_r;

endmodule
